l2_req_queue: RTL
=================

// Module: l2_req_queue
// PURPOSE
//  Request queue between the L1 data cache and the next-level (L2) cache model.
//  Captures each line-address request (read/write) the data cache emits and buffers it in a FIFO.
//  Issues requests to L2 over a valid/ready handshake and keeps issue/drop statistics.
//  The data cache cannot stall, so requests that arrive while the queue is full are dropped and counted.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  ADDR_W  26  line-address width (address bits [31:6])
//  CNT_W   32  statistics counter width
// PORTS
//  clk            in   1          clock; all state updates on posedge
//  rst_n          in   1          asynchronous, active-low reset
//  req_valid      in   1          data cache presents a request this cycle
//  req_cmd        in   2          01 = READ, 10 = WRITE; 00 and 11 are ignored
//  req_addr       in   ADDR_W     line address
//  req_ready      out  1          !full; informational only, upstream never stalls
//  flush          in   1          synchronous queue clear
//  l2_valid       out  1          head entry valid
//  l2_cmd         out  2          head command
//  l2_addr        out  ADDR_W     head line address
//  l2_ready       in   1          L2 accepts the head this cycle
//  occupancy      out  $clog2(DEPTH)+1  entries currently held
//  reads_issued   out  CNT_W      READ handshakes completed
//  writes_issued  out  CNT_W      WRITE handshakes completed
//  drops          out  CNT_W      legal requests lost because the queue was full
//  merged         out  CNT_W      writes coalesced (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n = 0, async): pointers = 0, occupancy = 0, l2_valid = 0, l2_cmd = 00, l2_addr = 0,
//    req_ready = 1, all counters = 0. Reset mid-transfer discards all queued entries.
//  - Push: at a posedge where req_valid & cmd is legal & !full, write the entry at the tail.
//    Illegal cmd (00/11): ignored; no push, no counter change.
//  - Pop: at a posedge where l2_valid & l2_ready. Advance the head and increment
//    reads_issued or writes_issued according to l2_cmd.
//  - Outputs: l2_valid = (occupancy != 0). l2_cmd and l2_addr show the head entry and stay stable
//    while l2_valid & !l2_ready. They are 0 when empty.
//  - Latency: an entry pushed at edge N into an empty queue shows l2_valid = 1 after edge N.
//    There is no same-cycle bypass.
//  - Simultaneous push and pop: both happen and occupancy is unchanged. req_ready is strictly !full,
//    so a push is refused when full even if a pop occurs in the same cycle.
//  - Full: a legal req_valid while full increments drops; the queue is unchanged.
//  - Pointers: log2(DEPTH)+1 bits with wrap bit; full = MSBs differ & LSBs equal; empty = equal.
//  - flush = 1: clears the pointers at the next edge. That cycle's push and pop are discarded.
//    Counters are preserved; flush has priority over push and pop.
//  - All counters saturate at all-ones and never wrap.
// CONFIGURATION
//  - Macro L2_REQ_MERGE_EN defined: a legal WRITE whose address equals the youngest queued entry,
//    when that entry is a WRITE, is not pushed and increments merged. This applies only if that entry
//    is not the head being popped in the same cycle. A coalesced write is accepted even when full,
//    so it does not count as a drop.
//  - Macro not defined: every legal request pushes normally; merged is tied to 0.
// STRUCTURE
//  - Package l2_if_pkg: CMD_IDLE = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10,
//    LINE_ADDR_W = 26, typedef l2_req_t {cmd, addr}.
//  - Sub-module req_fifo_mem: storage array plus head/tail pointers, full/empty/occupancy.
//  - Top level: accept/drop/merge logic, saturating counters, output mapping.
// TESTING
//  1 Reset: apply rst_n = 0 mid-stream with 3 entries held -> l2_valid = 0, occupancy = 0,
//    all counters = 0 asynchronously.
//  2 Order/latency: push READ 0x0000001 and WRITE 0x0000002 with l2_ready = 0; then l2_ready = 1
//    -> issue order READ then WRITE; reads_issued = 1, writes_issued = 1.
//  3 Full: with l2_ready = 0, push 10 legal requests -> occupancy = 8, req_ready = 0, drops = 2;
//    the head is the first request.
//  4 Push and pop together at occupancy 8 -> the push is dropped (drops + 1) and occupancy = 7.
//    At occupancy 3 -> occupancy stays 3.
//  5 Flush with 5 entries held -> l2_valid = 0 next cycle; issued counters unchanged;
//    a new push is visible one cycle later.
//  6 Merge: push WRITE 0x0ABCDEF twice back-to-back.
//    L2_REQ_MERGE_EN on -> occupancy = 1, merged = 1. Off -> occupancy = 2, merged = 0.

Source files
------------

// File: rtl/l2_if_pkg.sv
// rtl/l2_if_pkg.sv - shared command encodings and request type for the L1-to-L2 request path
package l2_if_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int LINE_ADDR_W = 26;

    typedef struct packed {
        logic [1:0]             cmd;
        logic [LINE_ADDR_W-1:0] addr;
    } l2_req_t;

    function automatic logic cmd_is_legal(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/req_fifo_mem.sv
// rtl/req_fifo_mem.sv - request storage with wrap-bit head/tail pointers and occupancy
module req_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               head_o,
    output logic [W-1:0]               tail_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] tail_idx;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the head view is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign tail_idx = wr_ptr_q[AW-1:0] - AW'(1);

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign tail_o  = mem_q[tail_idx];

endmodule

// File: rtl/l2_req_queue.sv
// rtl/l2_req_queue.sv - L1-to-L2 request queue with drop/issue statistics
// Optional write coalescing into the youngest entry: L2_REQ_MERGE_EN
module l2_req_queue
    import l2_if_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [1:0]                req_cmd,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      req_ready,
    input  logic                      flush,
    output logic                      l2_valid,
    output logic [1:0]                l2_cmd,
    output logic [ADDR_W-1:0]         l2_addr,
    input  logic                      l2_ready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [CNT_W-1:0]          reads_issued,
    output logic [CNT_W-1:0]          writes_issued,
    output logic [CNT_W-1:0]          drops,
    output logic [CNT_W-1:0]          merged
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 2 + ADDR_W;

    logic [ENT_W-1:0] head_entry, tail_entry;
    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic             req_legal, pop_raw, do_pop, merge_hit, do_push, do_drop;

    logic [CNT_W-1:0] reads_q, reads_d;
    logic [CNT_W-1:0] writes_q, writes_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic [CNT_W-1:0] merged_q, merged_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req_legal = req_valid && cmd_is_legal(req_cmd);
    assign pop_raw   = !fifo_empty && l2_ready;
    assign do_pop    = pop_raw && !flush;

`ifdef L2_REQ_MERGE_EN
    // With one entry held, the youngest entry is also the head; never merge into an entry leaving now.
    assign merge_hit = req_legal && (req_cmd == CMD_WRITE) && !fifo_empty
                    && (tail_entry[ENT_W-1 -: 2] == CMD_WRITE)
                    && (tail_entry[ADDR_W-1:0] == req_addr)
                    && !(pop_raw && (fifo_count == OCC_W'(1)));
`else
    logic unused_tail;
    assign unused_tail = ^tail_entry;
    assign merge_hit   = 1'b0;
`endif

    assign do_push = req_legal && !fifo_full && !merge_hit && !flush;
    assign do_drop = req_legal && fifo_full && !merge_hit && !flush;

    req_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .wdata_i ({req_cmd, req_addr}),
        .head_o  (head_entry),
        .tail_o  (tail_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        drops_d  = drops_q;
        merged_d = merged_q;
        if (do_pop && head_entry[ENT_W-1 -: 2] == CMD_READ)  reads_d  = sat_inc(reads_q);
        if (do_pop && head_entry[ENT_W-1 -: 2] == CMD_WRITE) writes_d = sat_inc(writes_q);
        if (do_drop)                                         drops_d  = sat_inc(drops_q);
        if (merge_hit && !flush)                             merged_d = sat_inc(merged_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            drops_q  <= '0;
            merged_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            drops_q  <= drops_d;
            merged_q <= merged_d;
        end
    end

    assign req_ready     = !fifo_full;
    assign l2_valid      = !fifo_empty;
    assign l2_cmd        = head_entry[ENT_W-1 -: 2];
    assign l2_addr       = head_entry[ADDR_W-1:0];
    assign occupancy     = fifo_count;
    assign reads_issued  = reads_q;
    assign writes_issued = writes_q;
    assign drops         = drops_q;
    assign merged        = merged_q;

endmodule
